// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg : opcodes, sequencer states, trap causes and ALU encodings  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package rv32_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    TC_NONE     = 2'd0,
    TC_ILLEGAL  = 2'd1,
    TC_FETCH_TO = 2'd2,
    TC_DATA_TO  = 2'd3
  } trap_cause_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  function automatic logic op_is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_IMM) || (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic op_is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_mem_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_mem_timeout : memory wait counter with expiry flag              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rv32_mem_timeout #(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [TO_W-1:0] c_LIMIT = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/rv32_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_seq_ctrl : multi-cycle RV32I sequencer (FETCH..WB, trap)        |
// | Optional cycle/instret counters: define RV32_SEQ_PERF_EN             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rv32_seq_ctrl
  import rv32_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic        ir_we,
  output logic        alu_en,
  output logic        reg_write,
  output logic        pc_we,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state_o
`ifdef RV32_SEQ_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  seq_state_e  r_state;
  seq_state_e  w_next;
  trap_cause_e r_cause;
  trap_cause_e w_cause;
  logic        w_wait;
  logic        w_at_limit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_cause <= TC_NONE;
    end else begin
      r_state <= w_next;
      if (w_next == ST_TRAP && r_state != ST_TRAP) begin
        r_cause <= w_cause;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cause   = TC_NONE;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_fetch = 1'b0;
    ir_we     = 1'b0;
    alu_en    = 1'b0;
    reg_write = 1'b0;
    pc_we     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        mem_fetch = 1'b1;
        ir_we     = mem_ack;
        if (mem_ack) begin
          w_next = ST_DECODE;
        end else if (w_at_limit) begin
          w_next  = ST_TRAP;
          w_cause = TC_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (op_is_legal(opcode)) begin
          w_next = ST_EXEC;
        end else begin
          w_next  = ST_TRAP;
          w_cause = TC_ILLEGAL;
        end
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        w_next = op_is_mem(opcode) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ack) begin
          w_next = ST_WB;
        end else if (w_at_limit) begin
          w_next  = ST_TRAP;
          w_cause = TC_DATA_TO;
        end
      end
      ST_WB: begin
        pc_we     = 1'b1;
        reg_write = (opcode != OP_STORE);
        w_next    = ST_FETCH;
      end
      ST_TRAP: begin
        w_next = ST_TRAP;
      end
      default: begin
        w_next  = ST_TRAP;
        w_cause = TC_ILLEGAL;
      end
    endcase
    // Strobes are forced quiet for the whole reset cycle, whatever the state.
    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_fetch = 1'b0;
      ir_we     = 1'b0;
      alu_en    = 1'b0;
      reg_write = 1'b0;
      pc_we     = 1'b0;
    end
  end

  assign w_wait = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ack;

  rv32_mem_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_next != r_state),
    .i_inc      (w_wait),
    .o_at_limit (w_at_limit)
  );

  assign trap       = (r_state == ST_TRAP);
  assign trap_cause = r_cause;
  assign state_o    = r_state;

`ifdef RV32_SEQ_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (pc_we) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule
`default_nettype wire
